// File: rtl/rect_fill_pkg.sv
// Shared types and default screen geometry for the rect_fill engine.
package rect_fill_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

    typedef enum logic [1:0] {
        MODE_SOLID,
        MODE_XSTRIPE,
        MODE_YSTRIPE,
        MODE_OUTLINE
    } mode_t;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

endpackage

// File: rtl/rect_fill_if.sv
// Request/plot bundle between the task controller (master) and rect_fill (slave).
interface rect_fill_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic                done;
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [X_W-1:0]      x1;
    logic [Y_W-1:0]      y1;
    logic [COLOUR_W-1:0] colour;
    logic [1:0]          mode;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

    modport master (
        output start, x0, y0, x1, y1, colour, mode,
        input  done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, x0, y0, x1, y1, colour, mode,
        output done, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/rect_scan_ctr.sv
// Column-major 2-D scan counter (y inner). Counters carry one spare bit so
// the right/bottom bound never wraps. Outline edge flag only with RECT_FILL_OUTLINE_EN.
module rect_scan_ctr #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           en,
    input  logic [X_W:0]   ld_x0,
    input  logic [Y_W:0]   ld_y0,
    input  logic [X_W:0]   ld_x1,
    input  logic [Y_W:0]   ld_y1,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
`ifdef RECT_FILL_OUTLINE_EN
    ,
    output logic           on_edge
`endif
);
    logic [X_W:0] x_q, x1_q;
    logic [Y_W:0] y_q, y0_q, y1_q;
`ifdef RECT_FILL_OUTLINE_EN
    logic [X_W:0] x0_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            y_q  <= '0;
            y0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
`ifdef RECT_FILL_OUTLINE_EN
            x0_q <= '0;
`endif
        end else if (load) begin
            x_q  <= ld_x0;
            y_q  <= ld_y0;
            y0_q <= ld_y0;
            x1_q <= ld_x1;
            y1_q <= ld_y1;
`ifdef RECT_FILL_OUTLINE_EN
            x0_q <= ld_x0;
`endif
        end else if (en) begin
            if (y_q == y1_q) begin
                y_q <= y0_q;
                x_q <= x_q + 1'b1;
            end else begin
                y_q <= y_q + 1'b1;
            end
        end
    end

    assign x    = x_q[X_W-1:0];
    assign y    = y_q[Y_W-1:0];
    assign last = (x_q == x1_q) && (y_q == y1_q);

`ifdef RECT_FILL_OUTLINE_EN
    assign on_edge = (x_q == x0_q) || (x_q == x1_q) || (y_q == y0_q) || (y_q == y1_q);
`endif

endmodule

// File: rtl/rect_fill.sv
// Rectangle / full-screen fill engine for the VGA adapter, one pixel per clock.
// Define RECT_FILL_OUTLINE_EN to enable the perimeter-only mode (mode 11).
module rect_fill
    import rect_fill_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input logic        clk,
    input logic        rst_n,
    rect_fill_if.slave bus
);
    localparam logic [X_W:0] X_MAX = (X_W+1)'(SCREEN_W - 1);
    localparam logic [Y_W:0] Y_MAX = (Y_W+1)'(SCREEN_H - 1);

    state_t              state, state_nx;
    mode_t               mode_q;
    logic [COLOUR_W-1:0] colour_q;
    logic [COLOUR_W-1:0] colour_c;
    logic [X_W:0]        cx1_c;
    logic [Y_W:0]        cy1_c;
    logic                empty_c;
    logic                plot_en;
    logic [X_W-1:0]      scan_x;
    logic [Y_W-1:0]      scan_y;
    logic                scan_last;
    logic                done_q;
    logic                plot_q;
    logic [X_W-1:0]      vx_q;
    logic [Y_W-1:0]      vy_q;
    logic [COLOUR_W-1:0] vc_q;
`ifdef RECT_FILL_OUTLINE_EN
    logic                scan_edge;
`endif

    // Clip only the far corner; an origin past the screen leaves the rect empty.
    always_comb begin
        cx1_c   = ({1'b0, bus.x1} > X_MAX) ? X_MAX : {1'b0, bus.x1};
        cy1_c   = ({1'b0, bus.y1} > Y_MAX) ? Y_MAX : {1'b0, bus.y1};
        empty_c = ({1'b0, bus.x0} > cx1_c) || ({1'b0, bus.y0} > cy1_c);
    end

    rect_scan_ctr #(.X_W(X_W), .Y_W(Y_W)) u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state == LOAD),
        .en      (state == FILL),
        .ld_x0   ({1'b0, bus.x0}),
        .ld_y0   ({1'b0, bus.y0}),
        .ld_x1   (cx1_c),
        .ld_y1   (cy1_c),
        .x       (scan_x),
        .y       (scan_y),
        .last    (scan_last)
`ifdef RECT_FILL_OUTLINE_EN
        ,
        .on_edge (scan_edge)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = LOAD;
            LOAD: state_nx = empty_c ? DONE : FILL;
            FILL: if (scan_last) state_nx = DONE;
            DONE: if (!bus.start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        case (mode_q)
            MODE_XSTRIPE: colour_c = scan_x[COLOUR_W-1:0];
            MODE_YSTRIPE: colour_c = scan_y[COLOUR_W-1:0];
            default:      colour_c = colour_q;
        endcase
`ifdef RECT_FILL_OUTLINE_EN
        plot_en = (mode_q != MODE_OUTLINE) || scan_edge;
`else
        plot_en = 1'b1;
`endif
    end

    // Outputs lag the counter by one register, so the last plot is visible
    // while the FSM is already in DONE; done itself follows a cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_SOLID;
            colour_q <= '0;
            plot_q   <= 1'b0;
            vx_q     <= '0;
            vy_q     <= '0;
            vc_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            if (state == LOAD) begin
                mode_q   <= mode_t'(bus.mode);
                colour_q <= bus.colour;
            end
            plot_q <= (state == FILL) && plot_en;
            if (state == FILL) begin
                vx_q <= scan_x;
                vy_q <= scan_y;
                vc_q <= colour_c;
            end
            // First DONE cycle always raises done; after that it tracks start.
            done_q <= (state == DONE) && (bus.start || !done_q);
        end
    end

    assign bus.done       = done_q;
    assign bus.vga_plot   = plot_q;
    assign bus.vga_x      = vx_q;
    assign bus.vga_y      = vy_q;
    assign bus.vga_colour = vc_q;

endmodule
